// File: rtl/seg_pkg.sv
// Shared glyphs, BCD sizing helper and controller FSM states for the
// seven-segment display controller.
package seg_pkg;

   // Active-high glyphs, bit0 = segment a ... bit6 = segment g
   localparam logic [6:0] SEG_0     = 7'h3F;
   localparam logic [6:0] SEG_1     = 7'h06;
   localparam logic [6:0] SEG_2     = 7'h5B;
   localparam logic [6:0] SEG_3     = 7'h4F;
   localparam logic [6:0] SEG_4     = 7'h66;
   localparam logic [6:0] SEG_5     = 7'h6D;
   localparam logic [6:0] SEG_6     = 7'h7D;
   localparam logic [6:0] SEG_7     = 7'h07;
   localparam logic [6:0] SEG_8     = 7'h7F;
   localparam logic [6:0] SEG_9     = 7'h6F;
   localparam logic [6:0] SEG_A     = 7'h77;
   localparam logic [6:0] SEG_B     = 7'h7C;
   localparam logic [6:0] SEG_C     = 7'h58;
   localparam logic [6:0] SEG_D     = 7'h5E;
   localparam logic [6:0] SEG_E     = 7'h79;
   localparam logic [6:0] SEG_F     = 7'h71;
   localparam logic [6:0] SEG_BLANK = 7'h00;
   localparam logic [6:0] SEG_DASH  = 7'h40;

   typedef enum logic [1:0] {IDLE, CONV, UPDATE} state_t;

   // Decimal digits needed to hold 2**width-1
   function automatic int BCD_DIGITS(input int width);
      longint unsigned v;
      int              d;
      v = (64'd1 << width) - 64'd1;
      d = 1;
      for (int i = 0; i < 20; i++) begin
         if (v >= 64'd10) begin
            v = v / 64'd10;
            d++;
         end
      end
      return d;
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Single-channel iterative double-dabble converter. The start cycle already
// performs the first shift, so the result is valid VALUE_W cycles after start.
module bin2bcd_seq
   import seg_pkg::*;
#(
   parameter int VALUE_W = 11,
   parameter int BCD_D   = BCD_DIGITS(VALUE_W)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [VALUE_W-1:0]   value,
   output logic                 busy,
   output logic                 valid,
   output logic [4*BCD_D-1:0]   bcd
);

   localparam int CNT_W = $clog2(VALUE_W + 1);

   logic [VALUE_W-1:0] shreg;
   logic [CNT_W-1:0]   cnt;
   logic [4*BCD_D-1:0] bcd_adj;

   function automatic logic [4*BCD_D-1:0] add3(input logic [4*BCD_D-1:0] b);
      logic [4*BCD_D-1:0] r;
      r = b;
      for (int d = 0; d < BCD_D; d++) begin
         if (r[4*d +: 4] >= 4'd5) r[4*d +: 4] = r[4*d +: 4] + 4'd3;
      end
      return r;
   endfunction

   assign bcd_adj = add3(bcd);

   always_ff @(posedge clk) begin
      if (reset) begin
         busy  <= 1'b0;
         valid <= 1'b0;
         cnt   <= '0;
      end else begin
         valid <= 1'b0;
         if (start) begin
            cnt   <= CNT_W'(VALUE_W - 1);
            busy  <= (VALUE_W > 1);
            valid <= (VALUE_W == 1);
         end else if (busy) begin
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
               busy  <= 1'b0;
               valid <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (start) begin
         bcd   <= {{(4*BCD_D-1){1'b0}}, value[VALUE_W-1]};
         shreg <= value << 1;
      end else if (busy) begin
         bcd   <= {bcd_adj[4*BCD_D-2:0], shreg[VALUE_W-1]};
         shreg <= shreg << 1;
      end
   end

endmodule

// File: rtl/seg_display_ctrl.sv
// Multi-channel binary to seven-segment controller: one shared BCD engine,
// staged results, and an atomic display/overflow update with a done pulse.
module seg_display_ctrl
   import seg_pkg::*;
#(
   parameter int CHANNELS   = 2,
   parameter int VALUE_W    = 11,
   parameter int DIGITS     = 3,
   parameter int ACTIVE_LOW = 1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [CHANNELS*VALUE_W-1:0]   values,
   input  logic                          mode_hex,
   input  logic                          blank_lz,
   input  logic                          load,
   output logic                          busy,
   output logic                          done,
   output logic [CHANNELS-1:0]           overflow,
   output logic [CHANNELS*DIGITS*7-1:0]  display
);

   localparam int BCD_D  = BCD_DIGITS(VALUE_W);
   localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int GRP_W  = DIGITS * 7;
   localparam int DISP_W = CHANNELS * GRP_W;
   localparam int XW     = 4*DIGITS + 4*BCD_D + VALUE_W;

   state_t             state_q, state_d;
   logic [CH_W-1:0]    ch_q, ch_nx;
   logic [VALUE_W-1:0] val_sh [CHANNELS];
   logic               mode_sh, blank_sh;
   logic [DISP_W-1:0]  stg_seg;
   logic [CHANNELS-1:0] stg_ovf;

   logic               accept, capture, ch_inc;
   logic               eng_start, eng_busy, eng_vld;
   logic [VALUE_W-1:0] eng_val;
   logic [4*BCD_D-1:0] eng_bcd;

   logic [XW-1:0]      cur_ext;
   logic [GRP_W-1:0]   cur_word;
   logic               cur_ovf, seen_nz;
   logic [3:0]         nib;

   function automatic logic [6:0] glyph(input logic [3:0] n);
      case (n)
         4'h0: return SEG_0;
         4'h1: return SEG_1;
         4'h2: return SEG_2;
         4'h3: return SEG_3;
         4'h4: return SEG_4;
         4'h5: return SEG_5;
         4'h6: return SEG_6;
         4'h7: return SEG_7;
         4'h8: return SEG_8;
         4'h9: return SEG_9;
         4'hA: return SEG_A;
         4'hB: return SEG_B;
         4'hC: return SEG_C;
         4'hD: return SEG_D;
         4'hE: return SEG_E;
         default: return SEG_F;
      endcase
   endfunction

   function automatic logic [DISP_W-1:0] polarity(input logic [DISP_W-1:0] w);
      return (ACTIVE_LOW != 0) ? ~w : w;
   endfunction

   assign ch_nx = ch_q + CH_W'(1);

   bin2bcd_seq #(
      .VALUE_W (VALUE_W),
      .BCD_D   (BCD_D)
   ) u_bin2bcd (
      .clk   (clk),
      .reset (reset),
      .start (eng_start),
      .value (eng_val),
      .busy  (eng_busy),
      .valid (eng_vld),
      .bcd   (eng_bcd)
   );

   // Digit source is the latched value (hex) or the engine result (decimal);
   // anything above the visible digits means overflow.
   always_comb begin
      cur_ext  = mode_sh ? XW'(val_sh[ch_q]) : XW'(eng_bcd);
      cur_ovf  = |cur_ext[XW-1:4*DIGITS];
      cur_word = '0;
      seen_nz  = 1'b0;
      nib      = '0;
      for (int d = DIGITS - 1; d >= 0; d--) begin
         nib = cur_ext[4*d +: 4];
         if (nib != 4'd0) seen_nz = 1'b1;
         if (cur_ovf)                              cur_word[7*d +: 7] = SEG_DASH;
         else if (blank_sh && !seen_nz && d != 0)  cur_word[7*d +: 7] = SEG_BLANK;
         else                                      cur_word[7*d +: 7] = glyph(nib);
      end
   end

   // Decimal mode starts the engine on the accepting edge straight from the
   // inputs so that channel 0 overlaps the shadow-register load.
   always_comb begin
      state_d   = state_q;
      accept    = 1'b0;
      capture   = 1'b0;
      ch_inc    = 1'b0;
      eng_start = 1'b0;
      eng_val   = '0;
      case (state_q)
         IDLE: begin
            if (load && !eng_busy) begin
               accept  = 1'b1;
               state_d = CONV;
               if (!mode_hex) begin
                  eng_start = 1'b1;
                  eng_val   = values[VALUE_W-1:0];
               end
            end
         end
         CONV: begin
            if (mode_sh || eng_vld) begin
               capture = 1'b1;
               if (ch_q == CH_W'(CHANNELS - 1)) begin
                  state_d = UPDATE;
               end else begin
                  ch_inc    = 1'b1;
                  eng_start = !mode_sh;
                  eng_val   = val_sh[ch_nx];
               end
            end
         end
         UPDATE:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         ch_q     <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         overflow <= '0;
         display  <= polarity('0);
      end else begin
         state_q <= state_d;
         done    <= 1'b0;
         if (accept) begin
            busy <= 1'b1;
            ch_q <= '0;
         end else if (ch_inc) begin
            ch_q <= ch_nx;
         end
         if (state_q == UPDATE) begin
            display  <= polarity(stg_seg);
            overflow <= stg_ovf;
            done     <= 1'b1;
            busy     <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         for (int c = 0; c < CHANNELS; c++) val_sh[c] <= values[c*VALUE_W +: VALUE_W];
         mode_sh  <= mode_hex;
         blank_sh <= blank_lz;
      end
      if (capture) begin
         stg_seg[ch_q*GRP_W +: GRP_W] <= cur_word;
         stg_ovf[ch_q]                <= cur_ovf;
      end
   end

endmodule
